// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and limits for the codec ADC deserializer
package audio_pkg;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_t;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        WAIT
    } deser_state_t;

    localparam int AUDIO_WIDTH_MAX = 32;
    localparam int CNT_W           = $clog2(AUDIO_WIDTH_MAX + 1);

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchronizer with a history stage for edge detection
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_hist;
    assign fall  = ~r_sync & r_hist;

endmodule

// File: rtl/audio_adc_deserializer.sv
// rtl/audio_adc_deserializer.sv - codec serial ADC stream to stereo pairs on clk
module audio_adc_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int I2S_DELAY  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  audio_BCLK,
    input  logic                  audio_ADCLRCK,
    input  logic                  audio_ADCDAT,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun,
    input  logic                  clear_overrun
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] SKIP_INIT = CNT_W'(I2S_DELAY);

    logic w_bclk_level_unused;
    logic w_bclk_rise;
    logic w_bclk_fall_unused;
    logic w_lrck_level;
    logic w_lrck_rise;
    logic w_lrck_fall;
    logic w_dat;
    logic w_dat_rise_unused;
    logic w_dat_fall_unused;

    sync_edge u_sync_bclk (
        .clk     (clk),
        .reset_n (reset_n),
        .i_pin   (audio_BCLK),
        .level   (w_bclk_level_unused),
        .rise    (w_bclk_rise),
        .fall    (w_bclk_fall_unused)
    );

    sync_edge u_sync_lrck (
        .clk     (clk),
        .reset_n (reset_n),
        .i_pin   (audio_ADCLRCK),
        .level   (w_lrck_level),
        .rise    (w_lrck_rise),
        .fall    (w_lrck_fall)
    );

    sync_edge u_sync_dat (
        .clk     (clk),
        .reset_n (reset_n),
        .i_pin   (audio_ADCDAT),
        .level   (w_dat),
        .rise    (w_dat_rise_unused),
        .fall    (w_dat_fall_unused)
    );

    deser_state_t          r_state;
    channel_t              r_channel;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CNT_W-1:0]      r_skip_cnt;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  r_left_fresh;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    logic                  r_valid;
    logic                  r_overrun;

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_lrck_edge;
    logic                  w_word_done;
    logic                  w_commit;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_drop;

    assign w_word      = {r_shift, w_dat};
    assign w_lrck_edge = w_lrck_rise | w_lrck_fall;
    assign w_word_done = (r_state == SHIFT) && !w_lrck_edge && w_bclk_rise
                         && (r_bit_cnt == LAST_BIT);
    assign w_commit    = w_word_done && (r_channel == RIGHT) && r_left_fresh;
    assign w_accept    = r_valid && ready;
    // A pair is only loaded when the output slot is free or being freed this cycle.
    assign w_load      = w_commit && (!r_valid || w_accept);
    assign w_drop      = w_commit && !w_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_channel    <= LEFT;
            r_bit_cnt    <= '0;
            r_skip_cnt   <= '0;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_left_fresh <= 1'b0;
            r_left       <= '0;
            r_right      <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Any LRCK edge starts a new word, aborting whatever was in progress.
            if (w_lrck_edge) begin
                r_channel  <= channel_t'(w_lrck_level);
                r_bit_cnt  <= '0;
                r_skip_cnt <= SKIP_INIT;
                r_state    <= (I2S_DELAY == 0) ? SHIFT : SKIP;
            end else begin
                case (r_state)
                    SKIP: begin
                        if (w_bclk_rise) begin
                            r_skip_cnt <= r_skip_cnt - 1'b1;
                            if (r_skip_cnt == CNT_W'(1)) begin
                                r_state <= SHIFT;
                            end
                        end
                    end
                    SHIFT: begin
                        if (w_bclk_rise) begin
                            r_shift   <= w_word[DATA_WIDTH-2:0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= WAIT;
                                if (r_channel == LEFT) begin
                                    r_left_hold  <= w_word;
                                    r_left_fresh <= 1'b1;
                                end else begin
                                    r_left_fresh <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (w_load) begin
                r_left  <= r_left_hold;
                r_right <= w_word;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign left_data  = r_left;
    assign right_data = r_right;
    assign valid      = r_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb/tb_audio_adc_deserializer.sv - directed scoreboard bench for the ADC deserializer
module tb_audio_adc_deserializer;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_bclk, a_lrck, a_dat, a_ready, a_clr;
    logic [15:0] a_left, a_right;
    logic        a_valid, a_ovr;

    logic        b_bclk, b_lrck, b_dat, b_ready, b_clr;
    logic [23:0] b_left, b_right;
    logic        b_valid, b_ovr;

    int checks = 0;
    int errors = 0;
    int hs_a   = 0;
    int hs_b   = 0;
    int hs0;

    logic [63:0] q_a[$];
    logic [63:0] q_b[$];

    always #10 clk = ~clk;

    audio_adc_deserializer #(.DATA_WIDTH(16), .I2S_DELAY(1)) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .audio_BCLK    (a_bclk),
        .audio_ADCLRCK (a_lrck),
        .audio_ADCDAT  (a_dat),
        .left_data     (a_left),
        .right_data    (a_right),
        .valid         (a_valid),
        .ready         (a_ready),
        .overrun       (a_ovr),
        .clear_overrun (a_clr)
    );

    audio_adc_deserializer #(.DATA_WIDTH(24), .I2S_DELAY(0)) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .audio_BCLK    (b_bclk),
        .audio_ADCLRCK (b_lrck),
        .audio_ADCDAT  (b_dat),
        .left_data     (b_left),
        .right_data    (b_right),
        .valid         (b_valid),
        .ready         (b_ready),
        .overrun       (b_ovr),
        .clear_overrun (b_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_pins(input int sel, input logic b, input logic lr, input logic d);
        if (sel == 0) begin
            a_bclk = b; a_lrck = lr; a_dat = d;
        end else begin
            b_bclk = b; b_lrck = lr; b_dat = d;
        end
    endtask

    // One LRCK half-period of nslots BCLKs; slots outside the word carry 1s.
    task automatic send_channel(input int sel, input logic lr, input logic [31:0] word,
                                input int width, input int delay, input int nslots,
                                input bit pulse_ready);
        for (int k = 0; k < nslots; k++) begin
            int   idx;
            logic d;
            idx = k - delay;
            d   = (idx >= 0 && idx < width) ? word[width-1-idx] : 1'b1;
            drive_pins(sel, 1'b0, lr, d);
            step(8);
            drive_pins(sel, 1'b1, lr, d);
            if (pulse_ready && k == delay + width - 1) begin
                step(2);
                a_ready = 1'b1;
                step(1);
                a_ready = 1'b0;
                step(5);
            end else begin
                step(8);
            end
        end
    endtask

    task automatic send_frame(input int sel, input logic [31:0] l, input logic [31:0] r,
                              input int width, input int delay, input bit pulse_ready);
        send_channel(sel, 1'b0, l, width, delay, 32, 1'b0);
        send_channel(sel, 1'b1, r, width, delay, 32, pulse_ready);
    endtask

    always @(negedge clk) begin
        if (a_valid && a_ready) begin
            hs_a++;
            checks++;
            assert (q_a.size() != 0) else begin
                errors++;
                $error("FAIL pair_a_unexpected: observed %h_%h expected none", a_left, a_right);
            end
            if (q_a.size() != 0) check("pair_a", {32'(a_left), 32'(a_right)}, q_a.pop_front());
        end
        if (b_valid && b_ready) begin
            hs_b++;
            checks++;
            assert (q_b.size() != 0) else begin
                errors++;
                $error("FAIL pair_b_unexpected: observed %h_%h expected none", b_left, b_right);
            end
            if (q_b.size() != 0) check("pair_b", {32'(b_left), 32'(b_right)}, q_b.pop_front());
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        a_bclk = 0; a_lrck = 0; a_dat = 0; a_ready = 0; a_clr = 0;
        b_bclk = 0; b_lrck = 0; b_dat = 0; b_ready = 0; b_clr = 0;
        step(4);
        reset_n = 1'b1;
        step(2);
        check("rst_a_left",  64'(a_left),  64'h0);
        check("rst_a_right", 64'(a_right), 64'h0);
        check("rst_a_valid", 64'(a_valid), 64'h0);
        check("rst_a_ovr",   64'(a_ovr),   64'h0);
        check("rst_b_left",  64'(b_left),  64'h0);
        check("rst_b_right", 64'(b_right), 64'h0);
        check("rst_b_valid", 64'(b_valid), 64'h0);
        check("rst_b_ovr",   64'(b_ovr),   64'h0);

        // I2S 16-bit frame with ready held high; leading right word is discarded
        a_ready = 1'b1;
        send_channel(0, 1'b1, 32'hFFFF, 16, 1, 32, 1'b0);
        hs0 = hs_a;
        q_a.push_back({32'h8001, 32'h7FFE});
        send_frame(0, 32'h8001, 32'h7FFE, 16, 1, 1'b0);
        step(4);
        check("t1_pulses", 64'(hs_a - hs0), 64'd1);
        check("t1_ovr",    64'(a_ovr),      64'h0);
        check("t1_valid",  64'(a_valid),    64'h0);

        // Left-justified 24-bit in 32-slot channels; trailing 1s must be ignored
        b_ready = 1'b1;
        send_channel(1, 1'b1, 32'hFFFFFF, 24, 0, 32, 1'b0);
        q_b.push_back({32'h123456, 32'hABCDEF});
        send_frame(1, 32'h123456, 32'hABCDEF, 24, 0, 1'b0);
        step(4);
        check("t2_pulses", 64'(hs_b), 64'd1);
        check("t2_ovr",    64'(b_ovr), 64'h0);

        // Reset released mid right word
        reset_n = 1'b0;
        send_channel(0, 1'b0, 32'h1111, 16, 1, 32, 1'b0);
        hs0 = hs_a;
        fork
            send_channel(0, 1'b1, 32'h2222, 16, 1, 32, 1'b0);
            begin
                step(160);
                check("t3_valid_in_reset", 64'(a_valid), 64'h0);
                reset_n = 1'b1;
            end
        join
        check("t3_no_pair", 64'(hs_a - hs0), 64'd0);
        q_a.push_back({32'h3333, 32'h4444});
        send_frame(0, 32'h3333, 32'h4444, 16, 1, 1'b0);
        step(4);
        check("t3_pulses", 64'(hs_a - hs0), 64'd1);

        // Overrun: ready low across two frames
        a_ready = 1'b0;
        hs0 = hs_a;
        q_a.push_back({32'hAAAA, 32'h5555});
        send_frame(0, 32'hAAAA, 32'h5555, 16, 1, 1'b0);
        send_frame(0, 32'hBBBB, 32'h6666, 16, 1, 1'b0);
        step(4);
        check("t4_valid", 64'(a_valid), 64'h1);
        check("t4_left",  64'(a_left),  64'hAAAA);
        check("t4_right", 64'(a_right), 64'h5555);
        check("t4_ovr",   64'(a_ovr),   64'h1);
        a_clr = 1'b1;
        step(1);
        a_clr = 1'b0;
        check("t4_ovr_clr", 64'(a_ovr), 64'h0);
        a_ready = 1'b1;
        step(2);
        check("t4_valid_after", 64'(a_valid), 64'h0);
        check("t4_pulses", 64'(hs_a - hs0), 64'd1);

        // LRCK toggles after 10 bits of a left word
        hs0 = hs_a;
        send_channel(0, 1'b0, 32'hF0F0, 16, 1, 11, 1'b0);
        send_channel(0, 1'b1, 32'h0F0F, 16, 1, 32, 1'b0);
        step(4);
        check("t5_abort_no_pair", 64'(hs_a - hs0), 64'd0);
        q_a.push_back({32'h1234, 32'h5678});
        send_frame(0, 32'h1234, 32'h5678, 16, 1, 1'b0);
        step(4);
        check("t5_pulses", 64'(hs_a - hs0), 64'd1);

        // ready asserted exactly in the commit cycle while valid is high
        a_ready = 1'b0;
        hs0 = hs_a;
        q_a.push_back({32'hCAFE, 32'hBEEF});
        send_frame(0, 32'hCAFE, 32'hBEEF, 16, 1, 1'b0);
        step(2);
        check("t6_first_valid", 64'(a_valid), 64'h1);
        check("t6_first_left",  64'(a_left),  64'hCAFE);
        q_a.push_back({32'h1357, 32'h2468});
        send_frame(0, 32'h1357, 32'h2468, 16, 1, 1'b1);
        check("t6_valid", 64'(a_valid), 64'h1);
        check("t6_left",  64'(a_left),  64'h1357);
        check("t6_right", 64'(a_right), 64'h2468);
        check("t6_ovr",   64'(a_ovr),   64'h0);
        a_ready = 1'b1;
        step(2);
        check("t6_valid_after", 64'(a_valid), 64'h0);
        check("t6_pulses", 64'(hs_a - hs0), 64'd2);

        check("end_q_a", 64'(q_a.size()), 64'd0);
        check("end_q_b", 64'(q_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
